// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives the two operands of an external 2-input gate.
// Manual mode passes debounced buttons to the operands; sweep mode steps
// through all four operand combinations, captures the truth table and
// compares it against EXPECT.
module gate_sweep_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter logic [3:0]  EXPECT          = 4'b1110
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] btn_i,
    output logic       a_o,
    output logic       b_o,
    input  logic       y_i,
    output logic [3:0] truth_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Button conditioning
    logic [3:0]           sync1_q;
    logic [3:0]           sync2_q;
    logic [3:0]           deb_q;
    logic [3:0]           deb_d;
    logic [3:0][DB_W-1:0] db_cnt_q;
    logic [3:0][DB_W-1:0] db_cnt_d;
    logic [1:0]           edge_q;     // previous debounced {clear, start}
    logic                 start_c;
    logic                 clear_c;

    // Sequencer
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       truth_q;
    logic [3:0]       truth_d;

    // Registered outputs
    logic a_q;
    logic a_d;
    logic b_q;
    logic b_d;
    logic busy_q;
    logic busy_d;
    logic done_q;
    logic done_d;
    logic pass_q;
    logic pass_d;

    // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign start_c = deb_q[2] & ~edge_q[0];
    assign clear_c = deb_q[3] & ~edge_q[1];

    // Synchronizer, debouncer and edge-detect registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            db_cnt_q <= '0;
            edge_q   <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
            edge_q   <= deb_q[3:2];
        end
    end

    // Next-state logic; outputs are precomputed from next-state so they register cleanly
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        truth_d = truth_q;
        a_d     = 1'b0;
        b_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_c) begin
                    state_d = S_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    truth_d = 4'd0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                truth_d[idx_q] = y_i;
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear has priority over any start in the same cycle
        if (clear_c) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            truth_d = 4'd0;
        end

        case (state_d)
            S_IDLE: begin
                a_d = deb_d[0];
                b_d = deb_d[1];
            end
            S_SETTLE, S_SAMPLE: begin
                a_d = idx_d[0];
                b_d = idx_d[1];
            end
            default: begin
                a_d = 1'b0;
                b_d = 1'b0;
            end
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (truth_d == EXPECT);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            truth_q <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            truth_q <= truth_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign truth_o = truth_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign pass_o  = pass_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with a modelled OR (or faulty AND) gate.
module tb_gate_sweep_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned ST = 3;

    logic       clk;
    logic       reset_i;
    logic [3:0] btn;
    logic       a_o;
    logic       b_o;
    logic       y_i;
    logic [3:0] truth_o;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
    logic       faulty;

    int checks = 0;
    int errors = 0;

    // Gate model: OR normally, AND when modelling a broken gate
    assign y_i = faulty ? (a_o & b_o) : (a_o | b_o);

    gate_sweep_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SETTLE_CYCLES  (ST),
        .EXPECT         (4'b1110)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .btn_i  (btn),
        .a_o    (a_o),
        .b_o    (b_o),
        .y_i    (y_i),
        .truth_o(truth_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .pass_o (pass_o)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle long enough for earlier debounced levels to settle, then hold the
    // buttons until the debounced level rises (edge E6); returns just after E6.
    task automatic press(input logic [3:0] mask);
        tick(8);
        btn = btn | mask;
        tick(6);
        btn = btn & ~mask;
    endtask

    // Start a sweep and follow it cycle by cycle into DONE
    task automatic sweep(input logic [3:0] exp_truth, input logic exp_pass, input bit poke_start);
        press(4'b0100);
        for (int k = 0; k < 16; k++) begin
            tick(1);
            check("sweep_step", {28'd0, busy_o, done_o, b_o, a_o},
                  {28'd0, 2'b10, 2'(k / 4)});
            if (k == 0) check("sweep_truth_cleared", {28'd0, truth_o}, 32'd0);
            if (poke_start && k == 6)  btn[2] = 1'b1;
            if (poke_start && k == 14) btn[2] = 1'b0;
        end
        tick(1);
        check("sweep_done_flags", {27'd0, busy_o, done_o, pass_o, b_o, a_o},
              {27'd0, 1'b0, 1'b1, exp_pass, 1'b0, 1'b0});
        check("sweep_truth", {28'd0, truth_o}, {28'd0, exp_truth});
    endtask

    initial begin
        reset_i = 1'b1;
        btn     = 4'd0;
        faulty  = 1'b0;
        tick(3);
        check("reset_outputs", {23'd0, a_o, b_o, truth_o, busy_o, done_o, pass_o}, 32'd0);
        reset_i = 1'b0;
        tick(2);

        // Short press of 3 cycles never reaches the debounced level
        btn[0] = 1'b1;
        tick(3);
        btn[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("short_press_a", {31'd0, a_o}, 32'd0);
        end
        tick(4);

        // Stable press: a_o rises exactly 6 cycles after the raw rise
        btn[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("debounce_latency_a", {31'd0, a_o}, (i == 6) ? 32'd1 : 32'd0);
        end
        check("manual_a_y", {31'd0, y_i}, 32'd1);
        btn[0] = 1'b0;
        tick(8);
        check("release_a", {31'd0, a_o}, 32'd0);

        // One-cycle glitch restarts the count; rise 6 cycles after the re-press
        btn[0] = 1'b1;
        tick(2);
        btn[0] = 1'b0;
        tick(1);
        btn[0] = 1'b1;
        tick(5);
        check("glitch_a_early", {31'd0, a_o}, 32'd0);
        tick(1);
        check("glitch_a_rise", {31'd0, a_o}, 32'd1);
        btn[0] = 1'b0;
        tick(8);
        check("glitch_release_a", {31'd0, a_o}, 32'd0);

        // Manual operand b
        btn[1] = 1'b1;
        tick(7);
        check("manual_b", {28'd0, b_o, y_i, busy_o, done_o}, {28'd0, 4'b1100});
        btn[1] = 1'b0;
        tick(8);
        check("manual_b_release", {31'd0, b_o}, 32'd0);

        // Good OR gate
        sweep(4'b1110, 1'b1, 1'b0);

        // Broken gate (AND), restart from DONE, extra start press mid-sweep ignored
        faulty = 1'b1;
        sweep(4'b1000, 1'b0, 1'b1);
        faulty = 1'b0;

        // Clear during idx=2 SETTLE aborts to IDLE
        press(4'b0100);
        for (int k = 0; k <= 8; k++) begin
            tick(1);
            if (k == 2) btn[3] = 1'b1;
        end
        check("abort_before", {27'd0, busy_o, b_o, a_o, truth_o[1:0]}, {27'd0, 5'b11010});
        tick(1);
        check("abort_after", {25'd0, busy_o, done_o, pass_o, b_o, a_o, truth_o[1:0]}, 32'd0);
        check("abort_truth", {28'd0, truth_o}, 32'd0);
        btn[3] = 1'b0;
        tick(4);
        check("abort_stays_idle", {30'd0, busy_o, done_o}, 32'd0);

        // Start and clear together from DONE: clear wins
        sweep(4'b1110, 1'b1, 1'b0);
        press(4'b1100);
        tick(1);
        check("start_clear_idle", {25'd0, busy_o, done_o, pass_o, truth_o}, 32'd0);
        tick(3);
        check("start_clear_stays", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset mid-sweep
        press(4'b0100);
        tick(5);
        check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
        #3;
        reset_i = 1'b1;
        #1;
        check("async_reset", {23'd0, a_o, b_o, truth_o, busy_o, done_o, pass_o}, 32'd0);
        #2;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", {23'd0, a_o, b_o, truth_o, busy_o, done_o, pass_o}, 32'd0);
        sweep(4'b1110, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Controller that sequences an external 2-input gate instance, such as or2, on the icebreaker board.
- Manual mode: debounced push-buttons drive the gate operands directly.
- Sweep mode: on a start press, the block steps the gate through all four operand combinations and captures the 4-bit truth table.
- After a sweep it compares the table against an expected pattern and drives a pass indicator, so a top can show gate correctness on LEDs.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required before a debounced button changes (10 ms at 12 MHz); must be >= 1.
- SETTLE_CYCLES, 16, cycles operands are held before y_i is sampled; must be >= 1.
- EXPECT, 4'b1110, expected truth table; bit k is the expected y for operands {b,a}=k (default is OR).

Ports:
- clk_i  input  1  board clock
- reset_i  input  1  asynchronous, active-high reset
- btn_i  input  4  raw async bouncy buttons, active-high: [0] operand a, [1] operand b, [2] start sweep, [3] clear
- a_o  output  1  operand a to gate
- b_o  output  1  operand b to gate
- y_i  input  1  gate result (combinational from a_o/b_o)
- truth_o  output  4  captured truth table, bit k = y for {b,a}=k
- busy_o  output  1  high while a sweep is in progress
- done_o  output  1  high in DONE
- pass_o  output  1  high in DONE when truth_o == EXPECT

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; sync flops, debounced values, edge regs, counters and idx all 0.
  - a_o=b_o=0, truth_o=0, busy_o=done_o=pass_o=0.
- Input conditioning, per btn_i bit:
  - 2-flop synchronizer, then debouncer.
  - The debounced value flips only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle resets that bit's counter.
  - Rising-edge detect on the debounced signal gives a one-cycle pulse.
  - Latency from a stable raw change to the debounced change is 2 + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, SETTLE, SAMPLE, DONE. idx is 2 bits; the settle counter is $clog2(SETTLE_CYCLES+1) bits.
- IDLE:
  - a_o/b_o follow debounced btn[0]/btn[1].
  - Start pulse: next cycle state=SETTLE, idx=0, cnt=0, truth_o=0.
- SETTLE:
  - a_o=idx[0], b_o=idx[1].
  - cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE next cycle.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - truth_o[idx] <= y_i.
  - If idx==3, go to DONE; else idx<=idx+1, cnt<=0, go to SETTLE.
- DONE:
  - truth_o held, done_o=1, pass_o=(truth_o==EXPECT), a_o=b_o=0.
  - Start pulse restarts the sweep as from IDLE, clearing truth_o.
- busy_o=1 exactly in SETTLE/SAMPLE. A full sweep is 4*(SETTLE_CYCLES+1) cycles, from the first SETTLE cycle to the first DONE cycle.
- Start pulses in SETTLE/SAMPLE are ignored; no restart.
- Clear pulse in any state: next cycle IDLE with truth_o=0, done_o=pass_o=0, idx=cnt=0. This aborts a sweep in progress.
- Clear and start pulses in the same cycle: clear wins.
- Operand buttons are ignored outside IDLE.
- Reset asserted mid-sweep returns immediately to the reset values.
- All outputs are registered or decoded from the state register only; there is no combinational path from btn_i or y_i to any output.

Test Plan (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3, EXPECT=4'b1110, y_i modelled as a_o|b_o):
- Debounce: btn[0] high for 3 cycles then low -> a_o stays 0. btn[0] held high -> a_o=1 exactly 6 cycles after the raw rise. A 1-cycle glitch during the count restarts it.
- Manual: btn[1] stable high in IDLE -> b_o=1 and y_i=1; busy_o/done_o stay 0.
- Full sweep: start press -> busy_o=1 for 16 cycles; {b_o,a_o} steps 00,01,10,11 for 4 cycles each. Then done_o=1, truth_o=4'b1110, pass_o=1.
- Faulty gate: model y_i=a_o&b_o, start -> truth_o=4'b1000, done_o=1, pass_o=0.
- Abort/simultaneous: clear pulse during idx=2 SETTLE -> IDLE next cycle with truth_o=0, busy_o=0. Start+clear in the same cycle from DONE -> IDLE. Start during a sweep -> no effect on timing.
- Reset mid-sweep: assert reset_i asynchronously between clock edges -> all outputs 0 immediately. After release, a start press runs a complete, correct sweep.
